imm_gen_pipe: RTL
=================

Name: imm_gen_pipe

Overview:
- Registered, parametrised successor to the combinational immediate generator.
- Sits between decode and the execute-stage register read.
- Extracts and extends immediates for RV32 or RV64 (XLEN), and adds CSR zimm decoding and illegal-select flagging.
- Carries a sideband tag and decouples decode from execute with a 2-entry valid/ready skid buffer, with flush support.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64. Sign extension is always from instr[31].
- TAG_W, 5, width of the opaque sideband tag (e.g. rd or ROB index) passed through unchanged.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous kill of all buffered entries
- in_valid  input  1  upstream beat valid
- in_ready  output  1  upstream may transfer
- in_instr  input  32  raw instruction word
- in_sel  input  3  immediate format select
- in_tag  input  TAG_W  sideband tag
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts
- out_imm  output  XLEN  extended immediate
- out_tag  output  TAG_W  tag of the output beat
- out_illegal  output  1  in_sel was 3'b111 for this beat

Behaviour:
- Decoding, per beat, at capture time:
  - 000 I-type: sext(instr[31:20]).
  - 001 shamt: zext(instr[24:20]) when XLEN=32; zext(instr[25:20]) when XLEN=64.
  - 010 S-type: sext({instr[31:25], instr[11:7]}).
  - 011 B-type: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - 100 U-type: sext({instr[31:12], 12'b0}); upper 32 bits are copies of bit 31 when XLEN=64.
  - 101 J-type: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - 110 Z-type (CSR zimm): zext(instr[19:15]).
  - 111: imm=0, illegal=1. Illegal is 0 for every other select.
- Storage: main register (drives out_*) and skid register, each holding {valid, imm, tag, illegal}.
- Handshake definitions:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = !skid_valid, taken straight from a flop with no combinational path from out_ready.
- Per cycle, when flush=0:
  - If main is empty or pop: main loads skid if skid_valid, else main loads the decoded input if accept, else main becomes empty. skid_valid clears when skid moves to main.
  - If skid was moved to main and accept is also true that cycle: the input beat goes into skid.
  - If main is full, no pop, and accept: skid loads the decoded input.
  - Invariant: skid_valid implies main_valid. Beat order is strictly FIFO. No beat is dropped or duplicated.
- Latency: 1 cycle from accept to out_valid when the buffer is empty. Throughput is 1 beat/cycle with out_ready held high.
- out_* are stable while out_valid=1 and out_ready=0.
- Flush:
  - Both valids are 0 on the next cycle, and in_ready=1 on the next cycle.
  - A beat accepted in the flush cycle is discarded.
  - A pop in the flush cycle still counts as delivered.
- Reset (rst_n low, asynchronous):
  - All valids are 0; out_imm, out_tag and out_illegal are 0.
  - in_ready is 1 once reset is released.
  - Assertion mid-transfer discards all buffered beats.
- No X propagation: default and illegal selects produce defined zeros.
- No simulation $display in synthesizable paths.

Test Plan:
- XLEN=32, instr 0xFFF00093 sel 000 with out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, illegal=0.
- XLEN=32, instr 0xFE000EE3 sel 011, tag 5'h07 -> out_imm=0xFFFFFFFC, out_tag=0x07.
- Backpressure: out_ready=0, three beats offered with tags 1,2,3:
  - tag1 sits in main, tag2 in skid, in_ready drops to 0 and tag3 is held.
  - Raise out_ready -> tags appear in order 1,2,3 on consecutive cycles, with no loss.
- XLEN=64:
  - 0x800000B7 sel 100 -> 0xFFFFFFFF80000000.
  - 0x03F09093 sel 001 -> 0x3F.
  - The same shamt instr with XLEN=32 -> 0x1F.
- Selects 110 and 111:
  - 0x000FD073 sel 110 -> out_imm=0x1F.
  - Any instr with sel 111 -> out_imm=0, out_illegal=1.
- Flush and reset:
  - Both entries full, pulse flush with in_valid=1 -> next cycle out_valid=0 and in_ready=1; the beat offered during flush never appears.
  - Repeat with rst_n pulsed low mid-cycle instead of flush -> out_* cleared immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe
// Brief    : Registered RV32/RV64 immediate generator behind a 2-entry
//            valid/ready skid buffer, with sideband tag and flush.
// Revision : 1.0
// ============================================================================
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [2:0]       in_sel,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_illegal
);

   localparam int c_SH_W = (XLEN == 64) ? 6 : 5;

   typedef struct packed {
      logic             valid;
      logic [XLEN-1:0]  imm;
      logic [TAG_W-1:0] tag;
      logic             illegal;
   } beat_t;

   logic [31:0]     w_raw;
   logic            w_sext;
   logic            w_illegal;
   logic [XLEN-1:0] w_imm;
   logic            w_accept;
   logic            w_pop;
   logic            w_opcode_unused;
   beat_t           w_in;
   beat_t           main_q;
   beat_t           main_d;
   beat_t           skid_q;
   beat_t           skid_d;

   // Opcode bits never contribute to any immediate format.
   assign w_opcode_unused = ^in_instr[6:0];

   // Every format is first built as a 32-bit value; widening to XLEN then
   // only needs to know whether bit 31 is replicated or zero-filled.
   always_comb begin
      w_raw     = 32'd0;
      w_sext    = 1'b0;
      w_illegal = 1'b0;
      case (in_sel)
         3'b000: begin
            w_raw  = {{20{in_instr[31]}}, in_instr[31:20]};
            w_sext = 1'b1;
         end
         3'b001: w_raw[c_SH_W-1:0] = in_instr[20 +: c_SH_W];
         3'b010: begin
            w_raw  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            w_sext = 1'b1;
         end
         3'b011: begin
            w_raw  = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
            w_sext = 1'b1;
         end
         3'b100: begin
            w_raw  = {in_instr[31:12], 12'd0};
            w_sext = 1'b1;
         end
         3'b101: begin
            w_raw  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0};
            w_sext = 1'b1;
         end
         3'b110: w_raw[4:0] = in_instr[19:15];
         default: w_illegal = 1'b1;
      endcase
      w_imm        = {XLEN{w_sext & w_raw[31]}};
      w_imm[31:0]  = w_raw;
      w_in.valid   = 1'b1;
      w_in.imm     = w_imm;
      w_in.tag     = in_tag;
      w_in.illegal = w_illegal;
   end

   // in_ready depends only on the skid flop, so out_ready never reaches it.
   assign in_ready = ~skid_q.valid;
   assign w_accept = in_valid & in_ready;
   assign w_pop    = main_q.valid & out_ready;

   always_comb begin
      main_d = main_q;
      skid_d = skid_q;
      if (flush) begin
         main_d.valid = 1'b0;
         skid_d.valid = 1'b0;
      end else if (!main_q.valid || w_pop) begin
         if (skid_q.valid) begin
            main_d       = skid_q;
            skid_d.valid = 1'b0;
            if (w_accept) begin
               skid_d = w_in;
            end
         end else if (w_accept) begin
            main_d = w_in;
         end else begin
            main_d.valid = 1'b0;
         end
      end else if (w_accept) begin
         skid_d = w_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         main_q <= main_d;
         skid_q <= skid_d;
      end
   end

   assign out_valid   = main_q.valid;
   assign out_imm     = main_q.imm;
   assign out_tag     = main_q.tag;
   assign out_illegal = main_q.illegal;

endmodule
`default_nettype wire
